// File: rtl/midi_pkg.sv
// Shared constants and FSM state type for the MIDI note-event scheduler.
package midi_pkg;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam int         DATA_W        = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STATUS = 2'd1,
    DATA1  = 2'd2,
    DATA2  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/midi_event_scheduler.sv
// Round-robin shares one MIDI UART TX among note-event requesters, framing
// each accepted event as Note On/Off bytes with optional running status.
module midi_event_scheduler
  import midi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CHANNEL        = 0,
  parameter int RUNNING_STATUS = 1
) (
  input  logic                   SYSCLK,
  input  logic                   SYSRESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_on,
  input  logic [7*NUM_REQ-1:0]   req_note,
  input  logic [7*NUM_REQ-1:0]   req_vel,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high. Requesters hold req_valid until accepted; tx_data/tx_valid
  // are held stable while tx_ready is low.

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [7:0]          status_q, status_d;
  logic [7:0]          last_status_q, last_status_d;
  logic                last_vld_q, last_vld_d;
  logic [DATA_W-1:0]   note_q, note_d;
  logic [DATA_W-1:0]   vel_q, vel_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       gidx;
  logic [7:0]          new_status;
  logic [DATA_W-1:0]   new_note, new_vel;
  logic                skip_status, hs;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .en        ((state_q == IDLE) && !SYSRESET),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign new_status  = {(req_on[gidx] ? MIDI_NOTE_ON : MIDI_NOTE_OFF), 4'(CHANNEL)};
  assign new_note    = req_note[7*int'(gidx) +: DATA_W];
  assign new_vel     = req_vel[7*int'(gidx) +: DATA_W];
  assign skip_status = (RUNNING_STATUS != 0) && last_vld_q && (new_status == last_status_q);
  assign hs          = tx_valid_q && tx_ready;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    status_d      = status_q;
    last_status_d = last_status_q;
    last_vld_d    = last_vld_q;
    note_d        = note_q;
    vel_d         = vel_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          status_d   = new_status;
          note_d     = new_note;
          vel_d      = new_vel;
          ptr_d      = gidx;
          tx_valid_d = 1'b1;
          if (skip_status) begin
            state_d   = DATA1;
            tx_data_d = {1'b0, new_note};
          end else begin
            state_d   = STATUS;
            tx_data_d = new_status;
          end
        end
      end
      STATUS: begin
        if (hs) begin
          last_status_d = status_q;
          last_vld_d    = 1'b1;
          state_d       = DATA1;
          tx_data_d     = {1'b0, note_q};
        end
      end
      DATA1: begin
        if (hs) begin
          state_d   = DATA2;
          tx_data_d = {1'b0, vel_q};
        end
      end
      DATA2: begin
        if (hs) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q       <= IDLE;
      ptr_q         <= IW'(NUM_REQ - 1);
      status_q      <= '0;
      last_status_q <= '0;
      last_vld_q    <= 1'b0;
      note_q        <= '0;
      vel_q         <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      status_q      <= status_d;
      last_status_q <= last_status_d;
      last_vld_q    <= last_vld_d;
      note_q        <= note_d;
      vel_q         <= vel_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
    end
  end

  assign req_ready = grant;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_midi_event_scheduler.sv
// Directed bench: instance a (channel 0, running status) and instance b
// (channel 3, no running status) driven in parallel.
module tb_midi_event_scheduler;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA1 = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_on, req_ready;
  logic [27:0] req_note, req_vel;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy;
  logic [1:0]  dbg_state;
  logic [3:0]  b_req_valid, b_req_on, b_req_ready;
  logic [27:0] b_req_note, b_req_vel;
  logic [7:0]  b_tx_data;
  logic        b_tx_valid, b_tx_ready, b_busy;
  logic [1:0]  b_dbg_state;

  int          checks = 0;
  int          fails  = 0;
  int          cyc_n  = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  b_exp_q[$];
  logic [7:0]  b_obs_q[$];
  int          obs_t[$];
  int          gnt_q[$];
  int          exp_g[$];
  bit          to;

  always #5 clk = ~clk;

  midi_event_scheduler #(.NUM_REQ(4), .CHANNEL(0), .RUNNING_STATUS(1)) dut_a (
    .SYSCLK(clk), .SYSRESET(rst), .req_valid(req_valid), .req_on(req_on),
    .req_note(req_note), .req_vel(req_vel), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  midi_event_scheduler #(.NUM_REQ(4), .CHANNEL(3), .RUNNING_STATUS(0)) dut_b (
    .SYSCLK(clk), .SYSRESET(rst), .req_valid(b_req_valid), .req_on(b_req_on),
    .req_note(b_req_note), .req_vel(b_req_vel), .req_ready(b_req_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // One clock: sample at negedge, advance past posedge, retire accepted requests.
  task automatic cyc();
    logic [3:0] acc, b_acc;
    @(negedge clk);
    acc   = req_valid & req_ready;
    b_acc = b_req_valid & b_req_ready;
    for (int i = 0; i < 4; i++) if (acc[i]) gnt_q.push_back(i);
    if (tx_valid && tx_ready) begin
      obs_q.push_back(tx_data);
      obs_t.push_back(cyc_n);
    end
    if (b_tx_valid && b_tx_ready) b_obs_q.push_back(b_tx_data);
    @(posedge clk);
    cyc_n++;
    #1;
    req_valid   = req_valid & ~acc;
    b_req_valid = b_req_valid & ~b_acc;
  endtask

  task automatic set_req(input int i, input logic on, input logic [6:0] note, input logic [6:0] vel);
    req_valid[i] = 1'b1;
    req_on[i]    = on;
    req_note[7*i +: 7] = note;
    req_vel[7*i +: 7]  = vel;
  endtask

  task automatic set_b_req(input int i, input logic on, input logic [6:0] note, input logic [6:0] vel);
    b_req_valid[i] = 1'b1;
    b_req_on[i]    = on;
    b_req_note[7*i +: 7] = note;
    b_req_vel[7*i +: 7]  = vel;
  endtask

  task automatic clear_logs();
    exp_q.delete(); obs_q.delete(); b_exp_q.delete(); b_obs_q.delete();
    obs_t.delete(); gnt_q.delete(); exp_g.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; b_req_valid = '0; tx_ready = 1'b1; b_tx_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (req_valid == 0 && b_req_valid == 0 && !busy && !b_busy) begin
        timed_out = 1'b0;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_ready = 1'b1; b_tx_ready = 1'b1;
    req_valid = 4'b0001; b_req_valid = 4'b0001;
    cyc(); cyc();
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dbg_state !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    req_valid = '0; b_req_valid = '0;
    rst = 1'b0;
    cyc();
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_idle_after: got valid=%b busy=%b expected 0 0", tx_valid, busy); end
    clear_logs();
  endtask

  task automatic test_single_note_on();
    do_reset();
    set_req(0, 1'b1, 7'd60, 7'd100);
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    cyc();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h90) begin fails++; $display("FAIL single_latency: got valid=%b data=%h expected 1 90", tx_valid, tx_data); end
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_ready_low: got %b expected 0000", req_ready); end
    run_idle(to);
    checks++; if (to) begin fails++; $display("FAIL single_timeout: got timeout expected idle"); end
    exp_q = '{8'h90, 8'h3C, 8'h64};
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL single_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL single_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_t.size() == 3) begin
      checks++; if (obs_t[2] - obs_t[0] != 2) begin fails++; $display("FAIL single_consecutive: got span %0d expected 2", obs_t[2] - obs_t[0]); end
    end
    checks++; if (gnt_q.size() != 1) begin fails++; $display("FAIL single_grants: got %0d expected 1", gnt_q.size()); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_running_status();
    do_reset();
    set_req(1, 1'b1, 7'd64, 7'd80);
    set_b_req(1, 1'b1, 7'd64, 7'd80);
    run_idle(to);
    set_req(1, 1'b1, 7'd67, 7'd80);
    set_b_req(1, 1'b1, 7'd67, 7'd80);
    run_idle(to);
    checks++; if (to) begin fails++; $display("FAIL rs_timeout: got timeout expected idle"); end
    exp_q   = '{8'h90, 8'h40, 8'h50, 8'h43, 8'h50};
    b_exp_q = '{8'h93, 8'h40, 8'h50, 8'h93, 8'h43, 8'h50};
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rs_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rs_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (b_obs_q.size() != b_exp_q.size()) begin fails++; $display("FAIL nors_count: got %0d expected %0d", b_obs_q.size(), b_exp_q.size()); end
    for (int i = 0; i < b_exp_q.size() && i < b_obs_q.size(); i++) begin
      checks++; if (b_obs_q[i] !== b_exp_q[i]) begin fails++; $display("FAIL nors_byte%0d: got %h expected %h", i, b_obs_q[i], b_exp_q[i]); end
    end
  endtask

  task automatic test_arbitration();
    int base;
    int exp_t[$];
    do_reset();
    set_req(0, 1'b1, 7'd10, 7'd20);
    set_req(1, 1'b1, 7'd11, 7'd21);
    set_req(2, 1'b1, 7'd12, 7'd22);
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL arb_onehot: got %b expected 0001", req_ready); end
    run_idle(to);
    checks++; if (to) begin fails++; $display("FAIL arb_timeout: got timeout expected idle"); end
    exp_g = '{0, 1, 2};
    exp_q = '{8'h90, 8'h0A, 8'h14, 8'h0B, 8'h15, 8'h0C, 8'h16};
    exp_t = '{0, 1, 2, 4, 5, 7, 8};
    checks++; if (gnt_q.size() != exp_g.size()) begin fails++; $display("FAIL arb_grant_count: got %0d expected %0d", gnt_q.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < gnt_q.size(); i++) begin
      checks++; if (gnt_q[i] != exp_g[i]) begin fails++; $display("FAIL arb_grant%0d: got %0d expected %0d", i, gnt_q[i], exp_g[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL arb_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    base = (obs_t.size() > 0) ? obs_t[0] : 0;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL arb_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
      checks++; if (obs_t[i] - base != exp_t[i]) begin fails++; $display("FAIL arb_time%0d: got %0d expected %0d", i, obs_t[i] - base, exp_t[i]); end
    end
    clear_logs();
    set_req(0, 1'b1, 7'd13, 7'd23);
    set_req(2, 1'b1, 7'd14, 7'd24);
    run_idle(to);
    exp_g = '{0, 2};
    exp_q = '{8'h0D, 8'h17, 8'h0E, 8'h18};
    checks++; if (gnt_q.size() != exp_g.size()) begin fails++; $display("FAIL arb2_grant_count: got %0d expected %0d", gnt_q.size(), exp_g.size()); end
    for (int i = 0; i < exp_g.size() && i < gnt_q.size(); i++) begin
      checks++; if (gnt_q[i] != exp_g[i]) begin fails++; $display("FAIL arb2_grant%0d: got %0d expected %0d", i, gnt_q[i], exp_g[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL arb2_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL arb2_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(3, 1'b1, 7'h7F, 7'h01);
    cyc();
    cyc();
    checks++; if (dbg_state !== S_DATA1) begin fails++; $display("FAIL bp_state: got %0d expected 2", dbg_state); end
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h7F) begin fails++; $display("FAIL bp_hold%0d: got valid=%b data=%h expected 1 7f", k, tx_valid, tx_data); end
    end
    tx_ready = 1'b1;
    run_idle(to);
    checks++; if (to) begin fails++; $display("FAIL bp_timeout: got timeout expected idle"); end
    exp_q = '{8'h90, 8'h7F, 8'h01};
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_status_change();
    do_reset();
    set_req(2, 1'b1, 7'd60, 7'd100); set_b_req(2, 1'b1, 7'd60, 7'd100);
    run_idle(to);
    set_req(2, 1'b0, 7'd60, 7'd0);   set_b_req(2, 1'b0, 7'd60, 7'd0);
    run_idle(to);
    set_req(2, 1'b1, 7'd60, 7'd0);   set_b_req(2, 1'b1, 7'd60, 7'd0);
    run_idle(to);
    checks++; if (to) begin fails++; $display("FAIL sc_timeout: got timeout expected idle"); end
    exp_q   = '{8'h90, 8'h3C, 8'h64, 8'h80, 8'h3C, 8'h00, 8'h90, 8'h3C, 8'h00};
    b_exp_q = '{8'h93, 8'h3C, 8'h64, 8'h83, 8'h3C, 8'h00, 8'h93, 8'h3C, 8'h00};
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL sc_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL sc_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (b_obs_q.size() != b_exp_q.size()) begin fails++; $display("FAIL sc_ch3_count: got %0d expected %0d", b_obs_q.size(), b_exp_q.size()); end
    for (int i = 0; i < b_exp_q.size() && i < b_obs_q.size(); i++) begin
      checks++; if (b_obs_q[i] !== b_exp_q[i]) begin fails++; $display("FAIL sc_ch3_byte%0d: got %h expected %h", i, b_obs_q[i], b_exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    set_req(0, 1'b1, 7'd60, 7'd100);
    cyc();
    cyc();
    checks++; if (dbg_state !== S_DATA1) begin fails++; $display("FAIL mid_state_before: got %0d expected 2", dbg_state); end
    rst = 1'b1;
    cyc();
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL mid_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (dbg_state !== S_IDLE) begin fails++; $display("FAIL mid_state_after: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    clear_logs();
    set_req(0, 1'b1, 7'd60, 7'd100);
    run_idle(to);
    checks++; if (to) begin fails++; $display("FAIL mid_timeout: got timeout expected idle"); end
    exp_q = '{8'h90, 8'h3C, 8'h64};
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL mid_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL mid_byte%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_on = '0; req_note = '0; req_vel = '0; tx_ready = 1'b1;
    b_req_valid = '0; b_req_on = '0; b_req_note = '0; b_req_vel = '0; b_tx_ready = 1'b1;
    test_reset();
    test_single_note_on();
    test_running_status();
    test_arbitration();
    test_backpressure();
    test_status_change();
    test_reset_mid_message();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/midi_event_scheduler.md
# midi_event_scheduler

Shares the single MIDI_TX UART transmitter between several note-event requesters: piezo trigger, cap button, XBee-relayed events, and spare inputs. The block round-robin arbitrates among the requesters, frames each accepted event into a MIDI Note On/Off message, and sequences its bytes into the UART byte interface with a valid/ready handshake. It sits in the wubsuit_base fabric between the sensor/event logic and the MIDI UART TX core, and optionally applies MIDI running status to cut bus time.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CHANNEL, 0, MIDI channel nibble (0..15) placed in every status byte
- RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last status byte sent

- SYSCLK  in  1  system clock; all logic is on the rising edge
- SYSRESET  in  1  reset; one clock, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester event pending; held until accepted
- req_on  in  NUM_REQ  per-requester 1 = Note On, 0 = Note Off
- req_note  in  7*NUM_REQ  per-requester note number; slice i is [7i+6:7i]
- req_vel  in  7*NUM_REQ  per-requester velocity; slice i is [7i+6:7i]
- req_ready  out  NUM_REQ  one-hot accept strobe; the event is taken on the edge where valid&ready
- tx_data  out  8  byte to the UART
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART accepts the byte on the edge where valid&ready
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, STATUS, DATA1, DATA2.
- IDLE:
  - When any req_valid is high, a grant is made combinationally by round robin. The search starts at the index after the last granted requester; after reset the pointer is NUM_REQ-1, so index 0 has first priority.
  - req_ready[g] is high that same cycle.
  - On the edge, the block latches the status byte {1'b1, req_on[g] ? 3'b001 : 3'b000, CHANNEL[3:0]}, the note and the velocity, and updates the pointer to g.
  - Next state is DATA1 when RUNNING_STATUS=1, last_status_vld=1 and the new status equals last_status. Otherwise next state is STATUS.
- STATUS: tx_data = status byte. On handshake: last_status <= status, last_status_vld <= 1, go to DATA1.
- DATA1: tx_data = {1'b0, note}. On handshake, go to DATA2.
- DATA2: tx_data = {1'b0, vel}. On handshake, go to IDLE.
- tx_valid is 1 in STATUS, DATA1 and DATA2, and 0 in IDLE.
- tx_data and tx_valid are registered outputs. tx_data is held stable while tx_valid=1 and tx_ready=0.
- req_ready is 0 in every state except IDLE. At most one bit is set.
- Velocity 0 with req_on=1 is sent unchanged as a Note On with velocity 0. No conversion is applied.
- Data bytes always have bit7 = 0. Inputs are 7 bits wide, so no masking is needed beyond zero-extension.

## Timing
- Reset values: state IDLE, tx_valid 0, tx_data 8'h00, req_ready 0, busy 0, last_status_vld 0, RR pointer NUM_REQ-1.
- Latency: accept edge at cycle N, then tx_valid=1 from cycle N+1.
- Throughput with tx_ready held at 1:
  - 4 cycles per message with a status byte (STATUS, DATA1, DATA2, IDLE accept).
  - 3 cycles per message under running status.
- Simultaneous req_valid: only the round-robin winner is accepted. The others keep their valid high and are served in later IDLE cycles, in rotating order.
- tx_ready may stay low for any number of cycles. The FSM stalls in place with outputs held.
- If a requester drops req_valid before acceptance, nothing is sent. Requesters must not do this (protocol rule); the block does not flag it.
- SYSRESET mid-message:
  - The partial message is abandoned and tx_valid is 0 on the next cycle.
  - last_status_vld is cleared, so the first message after reset always carries its status byte.
- SYSRESET has priority over all handshakes in the same cycle.

## Structure
- Package midi_pkg holds:
  - status nibble constants: MIDI_NOTE_OFF = 4'h8, MIDI_NOTE_ON = 4'h9
  - the state enum {IDLE, STATUS, DATA1, DATA2}
  - the data-byte width constant (7)
- Sub-module rr_arbiter, parameterized by N:
  - inputs: req vector, pointer, enable
  - outputs: one-hot grant and its encoded index
  - purely combinational
- The pointer register stays in the scheduler.

## Test plan
- Single Note On: req 0 with note 60 and vel 100, tx_ready=1. Expected: req_ready[0] pulses once; bytes 0x90, 0x3C, 0x64 on consecutive cycles; busy then drops.
- Running status: two Note On events on req 1 (note 64/vel 80, then note 67/vel 80). Expected: 0x90, 0x40, 0x50, 0x43, 0x50. With RUNNING_STATUS=0, 0x90 is repeated before 0x43.
- Arbitration: reqs 0, 1 and 2 all valid at once, each held. Expected grant order 0, 1, 2. Then re-assert 0 and 2 after 2 was last granted: expected order 0, then 2.
- Backpressure: tx_ready low for 5 cycles during DATA1. Expected: tx_data holds at the note byte, no byte is lost or duplicated, and the sequence completes after tx_ready rises.
- Status change: Note On ch 3 (CHANNEL=3), then Note Off for the same note. Expected: 0x93 … then 0x83 is sent, not suppressed.
- Reset mid-message: assert SYSRESET in DATA1. Expected next cycle: tx_valid=0 and state IDLE. The next accepted message starts with its status byte even when the status is the same.
